// File: rtl/fnd_scan_n.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS digits off a built-in refresh divider.
// Optional leading-zero suppression is enabled by defining FND_LZS_EN.
module fnd_scan_n #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 100000000,
   parameter int SCAN_HZ    = 960
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] hex_value,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank,
   output logic [7:0]              SEG,
   output logic [NUM_DIGITS-1:0]   DIGIT,
   output logic                    scan_tick
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   if (DIV < 2) begin : g_div_chk
      $error("fnd_scan_n: CLK_HZ/SCAN_HZ must be at least 2");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_nd_chk
      $error("fnd_scan_n: NUM_DIGITS must be in 1..8");
   end

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'h7E;
         4'h1: seg7 = 7'h30;
         4'h2: seg7 = 7'h6D;
         4'h3: seg7 = 7'h79;
         4'h4: seg7 = 7'h33;
         4'h5: seg7 = 7'h5B;
         4'h6: seg7 = 7'h5F;
         4'h7: seg7 = 7'h70;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h73;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h1F;
         4'hC: seg7 = 7'h4E;
         4'hD: seg7 = 7'h3D;
         4'hE: seg7 = 7'h4F;
         default: seg7 = 7'h47;
      endcase
   endfunction

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] digit_q, digit_d;
   logic                  tick_q, tick_d;
   logic                  tick;
   logic [IW-1:0]         sel;
   logic [3:0]            hex_sel;
   logic                  supp;

   // sel is the digit the next tick moves to, so outputs and index land together
   always_comb begin
      tick    = (cnt_q == CW'(DIV - 1));
      sel     = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      hex_sel = hex_value[4*int'(sel) +: 4];
      supp    = 1'b0;
`ifdef FND_LZS_EN
      begin
         logic higher_nz;
         higher_nz = 1'b0;
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j > int'(sel) && digit_en[j] && hex_value[4*j +: 4] != 4'h0)
               higher_nz = 1'b1;
         end
         supp = (sel != '0) && (hex_sel == 4'h0) && !higher_nz;
      end
`endif
   end

   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      seg_d   = seg_q;
      digit_d = digit_q;
      tick_d  = 1'b0;
      if (tick) begin
         cnt_d   = '0;
         idx_d   = sel;
         tick_d  = 1'b1;
         digit_d = ~(NUM_DIGITS'(1) << sel);
         if (blank || !digit_en[sel])
            seg_d = 8'h00;
         else if (supp)
            seg_d = {7'h00, dp[sel]};
         else
            seg_d = {seg7(hex_sel), dp[sel]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= IW'(NUM_DIGITS - 1);
         seg_q   <= 8'h00;
         digit_q <= '1;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         digit_q <= digit_d;
         tick_q  <= tick_d;
      end
   end

   assign SEG       = seg_q;
   assign DIGIT     = digit_q;
   assign scan_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_n.sv
// Directed bench for fnd_scan_n at DIV=10; expectations follow FND_LZS_EN when defined.
module tb_fnd_scan_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] hex_value;
   logic [3:0]  digit_en;
   logic [3:0]  dp;
   logic        blank;
   logic [7:0]  SEG;
   logic [3:0]  DIGIT;
   logic        scan_tick;

   int nvec = 0;
   int nerr = 0;

   fnd_scan_n #(.NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100)) dut (
      .clk(clk), .rst_n(rst_n), .hex_value(hex_value), .digit_en(digit_en),
      .dp(dp), .blank(blank), .SEG(SEG), .DIGIT(DIGIT), .scan_tick(scan_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Nine quiet edges (no tick, SEG held), then the update edge.
   task automatic step(input string tag, input logic [3:0] ed, input logic [7:0] es);
      logic [7:0] prev;
      prev = SEG;
      repeat (9) @(posedge clk);
      #1;
      chk({tag, "_quiet_tick"}, 32'(scan_tick), 32'd0);
      chk({tag, "_hold_seg"}, 32'(SEG), 32'(prev));
      @(posedge clk);
      #1;
      chk({tag, "_digit"}, 32'(DIGIT), 32'(ed));
      chk({tag, "_seg"}, 32'(SEG), 32'(es));
      chk({tag, "_tick"}, 32'(scan_tick), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      hex_value = 16'h3A05;
      digit_en  = 4'hF;
      dp        = 4'h0;
      blank     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digit", 32'(DIGIT), 32'hF);
      chk("rst_seg", 32'(SEG), 32'h00);
      chk("rst_tick", 32'(scan_tick), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step("s0", 4'hE, 8'hB6);
      step("s1", 4'hD, 8'hFC);
      step("s2", 4'hB, 8'hEE);
      step("s3", 4'h7, 8'hF2);
      step("s0w", 4'hE, 8'hB6);
      @(posedge clk);
      #1;
      chk("tick_one_cycle", 32'(scan_tick), 32'd0);

      // mid-period change must not show until the next update
      repeat (3) @(posedge clk);
      #1;
      hex_value = 16'h3A15;
      chk("hold_mid", 32'(SEG), 32'hB6);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_late", 32'(SEG), 32'hB6);
      @(posedge clk);
      #1;
      chk("hold_new_digit", 32'(DIGIT), 32'hD);
      chk("hold_new_seg", 32'(SEG), 32'h60);
      hex_value = 16'h3A05;

      blank = 1'b1;
      step("bl2", 4'hB, 8'h00);
      step("bl3", 4'h7, 8'h00);
      step("bl0", 4'hE, 8'h00);
      step("bl1", 4'hD, 8'h00);
      blank = 1'b0;

      digit_en = 4'b1101;
      step("en2", 4'hB, 8'hEE);
      step("en3", 4'h7, 8'hF2);
      step("en0", 4'hE, 8'hB6);
      step("en1", 4'hD, 8'h00);
      digit_en = 4'hF;

      dp = 4'b0001;
      step("dp2", 4'hB, 8'hEE);
      step("dp3", 4'h7, 8'hF2);
      step("dp0", 4'hE, 8'hB7);
      dp = 4'b0000;

      step("pr1", 4'hD, 8'hFC);
      step("pr2", 4'hB, 8'hEE);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_digit", 32'(DIGIT), 32'hF);
      chk("arst_seg", 32'(SEG), 32'h00);
      chk("arst_tick", 32'(scan_tick), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("rs0", 4'hE, 8'hB6);

      hex_value = 16'h0070;
      step("lz70_1", 4'hD, 8'hE0);
`ifdef FND_LZS_EN
      step("lz70_2", 4'hB, 8'h00);
      step("lz70_3", 4'h7, 8'h00);
`else
      step("lz70_2", 4'hB, 8'hFC);
      step("lz70_3", 4'h7, 8'hFC);
`endif
      step("lz70_0", 4'hE, 8'hFC);

      hex_value = 16'h0000;
      dp        = 4'b0100;
`ifdef FND_LZS_EN
      step("lz00_1", 4'hD, 8'h00);
      step("lz00_2dp", 4'hB, 8'h01);
      step("lz00_3", 4'h7, 8'h00);
`else
      step("lz00_1", 4'hD, 8'hFC);
      step("lz00_2dp", 4'hB, 8'hFD);
      step("lz00_3", 4'h7, 8'hFC);
`endif
      step("lz00_0", 4'hE, 8'hFC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
